// File: rtl/rf_wr_pkg.sv
// Shared types for register-file write-port clients and arbiters.
// Holds the write-arbiter state encoding and its width.
package rf_wr_pkg;

   localparam int unsigned state_width = 2;

   typedef enum logic [state_width-1:0] {
      IDLE    = 2'd0,
      WRITING = 2'd1,
      ACK     = 2'd2
   } e_rf_wr_arb_state;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr, wrapping past num_clients-1.
module rr_picker #(
   parameter int unsigned num_clients = 4,
   parameter int unsigned idx_width   = (num_clients > 1) ? $clog2(num_clients) : 1
) (
   input  logic [num_clients-1:0] req,
   input  logic [idx_width-1:0]   ptr,
   output logic                   found,
   output logic [idx_width-1:0]   idx
);

   logic [idx_width-1:0] cand;
   int unsigned          sum;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      sum   = 0;
      for (int unsigned off = 0; off < num_clients; off++) begin
         sum = int'(ptr) + off;
         if (sum >= num_clients) sum = sum - num_clients;
         cand = idx_width'(sum);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among execution units.
// Grants are latched; a one-cycle ack returns to the winner once the regfile accepts.
module rf_wr_arbiter
   import rf_wr_pkg::*;
#(
   parameter  int unsigned num_clients   = 4,
   parameter  int unsigned data_width    = 32,
   parameter  int unsigned num_regs      = 32,
   localparam int unsigned reg_sel_width = $clog2(num_regs),
   localparam int unsigned idx_width     = (num_clients > 1) ? $clog2(num_clients) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [num_clients-1:0]             cli_wr_req,
   input  logic [num_clients*reg_sel_width-1:0] cli_wr_sel,
   input  logic [num_clients*data_width-1:0]  cli_wr_data,
   output logic [num_clients-1:0]             cli_wr_ack,
   output logic                               rf_wr_req,
   output logic [reg_sel_width-1:0]           rf_wr_sel,
   output logic [data_width-1:0]              rf_wr_data,
   input  logic                               rf_wr_ack,
   output logic                               busy
);

   e_rf_wr_arb_state state, next_state;

   logic [idx_width-1:0]     rr_ptr, next_rr_ptr;
   logic [idx_width-1:0]     lat_idx, next_lat_idx;
   logic [reg_sel_width-1:0] lat_sel, next_lat_sel;
   logic [data_width-1:0]    lat_data, next_lat_data;

   logic [num_clients-1:0]   next_cli_wr_ack;
   logic                     next_rf_wr_req;
   logic [reg_sel_width-1:0] next_rf_wr_sel;
   logic [data_width-1:0]    next_rf_wr_data;
   logic                     next_busy;

   logic                     pick_found;
   logic [idx_width-1:0]     pick_idx;

   logic [reg_sel_width-1:0] sel_arr  [num_clients];
   logic [data_width-1:0]    data_arr [num_clients];

   for (genvar g = 0; g < num_clients; g++) begin : g_unpack
      assign sel_arr[g]  = cli_wr_sel[g*reg_sel_width +: reg_sel_width];
      assign data_arr[g] = cli_wr_data[g*data_width +: data_width];
   end

   rr_picker #(
      .num_clients (num_clients),
      .idx_width   (idx_width)
   ) u_picker (
      .req   (cli_wr_req),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      next_state      = state;
      next_rr_ptr     = rr_ptr;
      next_lat_idx    = lat_idx;
      next_lat_sel    = lat_sel;
      next_lat_data   = lat_data;
      next_cli_wr_ack = '0;
      next_rf_wr_req  = rf_wr_req;
      next_rf_wr_sel  = rf_wr_sel;
      next_rf_wr_data = rf_wr_data;
      case (state)
         IDLE: begin
            if (pick_found) begin
               next_lat_idx  = pick_idx;
               next_lat_sel  = sel_arr[pick_idx];
               next_lat_data = data_arr[pick_idx];
               // Writes to x0 skip the regfile and are acknowledged directly.
               if (sel_arr[pick_idx] != '0) begin
                  next_rf_wr_req  = 1'b1;
                  next_rf_wr_sel  = sel_arr[pick_idx];
                  next_rf_wr_data = data_arr[pick_idx];
                  next_state      = WRITING;
               end else begin
                  next_cli_wr_ack[pick_idx] = 1'b1;
                  next_state                = ACK;
               end
            end
         end
         WRITING: begin
            next_rf_wr_sel  = lat_sel;
            next_rf_wr_data = lat_data;
            if (rf_wr_ack) begin
               next_rf_wr_req           = 1'b0;
               next_cli_wr_ack[lat_idx] = 1'b1;
               next_state               = ACK;
            end
         end
         ACK: begin
            next_rr_ptr = (lat_idx == idx_width'(num_clients - 1)) ? '0
                                                                   : idx_width'(lat_idx + 1'b1);
            next_state  = IDLE;
         end
         default: begin
            next_state      = IDLE;
            next_lat_idx    = '0;
            next_lat_sel    = '0;
            next_lat_data   = '0;
            next_rf_wr_req  = 1'b0;
            next_rf_wr_sel  = '0;
            next_rf_wr_data = '0;
         end
      endcase
      next_busy = (next_state != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         lat_idx    <= '0;
         lat_sel    <= '0;
         lat_data   <= '0;
         cli_wr_ack <= '0;
         rf_wr_req  <= 1'b0;
         rf_wr_sel  <= '0;
         rf_wr_data <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= next_state;
         rr_ptr     <= next_rr_ptr;
         lat_idx    <= next_lat_idx;
         lat_sel    <= next_lat_sel;
         lat_data   <= next_lat_data;
         cli_wr_ack <= next_cli_wr_ack;
         rf_wr_req  <= next_rf_wr_req;
         rf_wr_sel  <= next_rf_wr_sel;
         rf_wr_data <= next_rf_wr_data;
         busy       <= next_busy;
      end
   end

   assert_known: assert property (@(posedge clk) disable iff (rst)
      !$isunknown({cli_wr_req, rf_wr_ack}) && (state inside {IDLE, WRITING, ACK}));

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed self-checking bench for rf_wr_arbiter with four clients.
// Client and regfile behaviour is driven from tasks; inputs change on the falling edge.
module tb_rf_wr_arbiter;

   logic         clk;
   logic         rst;
   logic [3:0]   cli_wr_req;
   logic [19:0]  cli_wr_sel;
   logic [127:0] cli_wr_data;
   logic [3:0]   cli_wr_ack;
   logic         rf_wr_req;
   logic [4:0]   rf_wr_sel;
   logic [31:0]  rf_wr_data;
   logic         rf_wr_ack;
   logic         busy;

   int errors;
   int checks;

   rf_wr_arbiter #(
      .num_clients (4),
      .data_width  (32),
      .num_regs    (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cli_wr_req  (cli_wr_req),
      .cli_wr_sel  (cli_wr_sel),
      .cli_wr_data (cli_wr_data),
      .cli_wr_ack  (cli_wr_ack),
      .rf_wr_req   (rf_wr_req),
      .rf_wr_sel   (rf_wr_sel),
      .rf_wr_data  (rf_wr_data),
      .rf_wr_ack   (rf_wr_ack),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_client(input int i, input logic [4:0] s, input logic [31:0] d);
      cli_wr_req[i]           = 1'b1;
      cli_wr_sel[i*5 +: 5]    = s;
      cli_wr_data[i*32 +: 32] = d;
   endtask

   // Plays the regfile (acks after 'stall' cycles of rf_wr_req) and the clients (drop req on ack).
   task automatic serve(input int stall, input logic mutate,
                        output logic [3:0] ack, output logic [4:0] sel, output logic [31:0] data,
                        output logic stable, output logic timeout);
      int   held;
      logic saw_rf;
      logic acked;
      held = 0; saw_rf = 1'b0; acked = 1'b0;
      ack = '0; sel = '0; data = '0; stable = 1'b1; timeout = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         rf_wr_ack = 1'b0;
         if (cli_wr_ack != 4'b0000) begin
            ack = cli_wr_ack;
            if (rf_wr_req) stable = 1'b0;
            cli_wr_req = cli_wr_req & ~cli_wr_ack;
            timeout = 1'b0;
            break;
         end
         if (rf_wr_req) begin
            if (!saw_rf) begin
               saw_rf = 1'b1;
               sel    = rf_wr_sel;
               data   = rf_wr_data;
            end else if (rf_wr_sel !== sel || rf_wr_data !== data) begin
               stable = 1'b0;
            end
            if (mutate && held == 1) cli_wr_data = ~cli_wr_data;
            if (held == stall) begin
               rf_wr_ack = 1'b1;
               acked     = 1'b1;
            end
            held++;
         end else if (saw_rf && !acked) begin
            stable = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({cli_wr_ack, rf_wr_req, rf_wr_sel, rf_wr_data, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ack=%b req=%b sel=%0d data=%h busy=%b, required all 0",
                  cli_wr_ack, rf_wr_req, rf_wr_sel, rf_wr_data, busy);
      end
      rst = 1'b0;
      rf_wr_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rf_wr_ack = 1'b0;
      checks++;
      if ({cli_wr_ack, rf_wr_req, busy} !== '0) begin
         errors++;
         $display("FAIL stray_rf_ack: ack=%b req=%b busy=%b, required 0", cli_wr_ack, rf_wr_req, busy);
      end
   endtask

   task automatic test_single;
      set_client(2, 5'd5, 32'hDEADBEEF);
      @(negedge clk);
      checks++;
      if (rf_wr_req !== 1'b1 || rf_wr_sel !== 5'd5 || rf_wr_data !== 32'hDEADBEEF ||
          busy !== 1'b1 || cli_wr_ack !== 4'b0000) begin
         errors++;
         $display("FAIL single_issue: req=%b sel=%0d data=%h busy=%b ack=%b, required 1 5 deadbeef 1 0000",
                  rf_wr_req, rf_wr_sel, rf_wr_data, busy, cli_wr_ack);
      end
      rf_wr_ack = 1'b1;
      @(negedge clk);
      rf_wr_ack = 1'b0;
      checks++;
      if (rf_wr_req !== 1'b0 || cli_wr_ack !== 4'b0100) begin
         errors++;
         $display("FAIL single_ack: req=%b ack=%b, required 0 0100", rf_wr_req, cli_wr_ack);
      end
      cli_wr_req[2] = 1'b0;
      @(negedge clk);
      checks++;
      if (cli_wr_ack !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_done: ack=%b busy=%b, required 0000 0", cli_wr_ack, busy);
      end
   endtask

   task automatic test_sel_zero;
      set_client(3, 5'd0, 32'h0000_0055);
      @(negedge clk);
      checks++;
      if (cli_wr_ack !== 4'b1000 || rf_wr_req !== 1'b0) begin
         errors++;
         $display("FAIL x0_ack: ack=%b req=%b, required 1000 0", cli_wr_ack, rf_wr_req);
      end
      cli_wr_req[3] = 1'b0;
      @(negedge clk);
      checks++;
      if (cli_wr_ack !== 4'b0000 || rf_wr_req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL x0_done: ack=%b req=%b busy=%b, required 0000 0 0", cli_wr_ack, rf_wr_req, busy);
      end
   endtask

   task automatic test_all_four;
      logic [3:0]  ack, exp_ack;
      logic [4:0]  sel;
      logic [31:0] data;
      logic        stable, timeout;
      for (int i = 0; i < 4; i++) set_client(i, 5'(i + 1), 32'hA000_0000 + 32'(i));
      for (int k = 0; k < 4; k++) begin
         serve(0, 1'b0, ack, sel, data, stable, timeout);
         exp_ack = 4'b0001 << k;
         checks++;
         if (timeout || ack !== exp_ack || sel !== 5'(k + 1) || data !== 32'hA000_0000 + 32'(k) || !stable) begin
            errors++;
            $display("FAIL rr_grant%0d: timeout=%b ack=%b sel=%0d data=%h clean=%b, required ack=%b sel=%0d data=%h",
                     k, timeout, ack, sel, data, stable, exp_ack, k + 1, 32'hA000_0000 + 32'(k));
         end
      end
      @(negedge clk);
      checks++;
      if (cli_wr_ack !== 4'b0000 || rf_wr_req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rr_drained: ack=%b req=%b busy=%b, required 0000 0 0", cli_wr_ack, rf_wr_req, busy);
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0]  ack;
      logic [4:0]  sel;
      logic [31:0] data;
      logic        stable, timeout;
      set_client(0, 5'd7, 32'h0000_0011);
      set_client(1, 5'd8, 32'h0000_0022);
      serve(0, 1'b0, ack, sel, data, stable, timeout);
      checks++;
      if (timeout || ack !== 4'b0001 || sel !== 5'd7 || data !== 32'h11) begin
         errors++;
         $display("FAIL b2b_first: ack=%b sel=%0d data=%h, required 0001 7 00000011", ack, sel, data);
      end
      set_client(0, 5'd9, 32'h0000_0033);
      serve(0, 1'b0, ack, sel, data, stable, timeout);
      checks++;
      if (timeout || ack !== 4'b0010 || sel !== 5'd8 || data !== 32'h22) begin
         errors++;
         $display("FAIL b2b_second: ack=%b sel=%0d data=%h, required 0010 8 00000022", ack, sel, data);
      end
      serve(0, 1'b0, ack, sel, data, stable, timeout);
      checks++;
      if (timeout || ack !== 4'b0001 || sel !== 5'd9 || data !== 32'h33) begin
         errors++;
         $display("FAIL b2b_third: ack=%b sel=%0d data=%h, required 0001 9 00000033", ack, sel, data);
      end
      @(negedge clk);
   endtask

   task automatic test_stall;
      logic [3:0]  ack;
      logic [4:0]  sel;
      logic [31:0] data;
      logic        stable, timeout;
      set_client(1, 5'd12, 32'hCAFEF00D);
      serve(5, 1'b1, ack, sel, data, stable, timeout);
      checks++;
      if (timeout || ack !== 4'b0010 || sel !== 5'd12 || data !== 32'hCAFEF00D || !stable) begin
         errors++;
         $display("FAIL stall_hold: timeout=%b ack=%b sel=%0d data=%h stable=%b, required 0 0010 12 cafef00d 1",
                  timeout, ack, sel, data, stable);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_write;
      logic [3:0]  ack;
      logic [4:0]  sel;
      logic [31:0] data;
      logic        stable, timeout;
      set_client(2, 5'd3, 32'h0000_0077);
      @(negedge clk);
      checks++;
      if (rf_wr_req !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midrst_writing: req=%b busy=%b, required 1 1", rf_wr_req, busy);
      end
      rst = 1'b1;
      cli_wr_req = '0;
      @(negedge clk);
      checks++;
      if ({cli_wr_ack, rf_wr_req, rf_wr_sel, rf_wr_data, busy} !== '0) begin
         errors++;
         $display("FAIL midrst_outputs: ack=%b req=%b sel=%0d data=%h busy=%b, required all 0",
                  cli_wr_ack, rf_wr_req, rf_wr_sel, rf_wr_data, busy);
      end
      rst = 1'b0;
      set_client(1, 5'd4, 32'h0000_0041);
      set_client(3, 5'd6, 32'h0000_0043);
      serve(0, 1'b0, ack, sel, data, stable, timeout);
      checks++;
      if (timeout || ack !== 4'b0010 || sel !== 5'd4 || data !== 32'h41) begin
         errors++;
         $display("FAIL midrst_ptr0: ack=%b sel=%0d data=%h, required 0010 4 00000041", ack, sel, data);
      end
      serve(0, 1'b0, ack, sel, data, stable, timeout);
      checks++;
      if (timeout || ack !== 4'b1000 || sel !== 5'd6 || data !== 32'h43) begin
         errors++;
         $display("FAIL midrst_next: ack=%b sel=%0d data=%h, required 1000 6 00000043", ack, sel, data);
      end
      @(negedge clk);
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      rst         = 1'b1;
      cli_wr_req  = '0;
      cli_wr_sel  = '0;
      cli_wr_data = '0;
      rf_wr_ack   = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      test_single;
      test_sel_zero;
      test_all_four;
      test_back_to_back;
      test_stall;
      test_reset_mid_write;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
